// File: rtl/freq_pkg.sv
// Shared constants and FSM encoding for the frequency-measurement sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package freq_pkg;

  localparam int CNT_W_DEF       = 26;          // edge count / memory data width
  localparam int ADDR_W          = 2;           // sample memory address width
  localparam int DEPTH           = 4;           // sample memory entries
  localparam int GATE_CYCLES_DEF = 100_000_000; // 1 s gate at 100 MHz

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GATE  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

// File: rtl/freq_gate_sequencer_if.sv
// Write channel from the gate sequencer into the 4-entry sample memory.
// Latency: n/a (wires only).
// Backpressure: sequencer holds wr_valid/addr_w/data_w until wr_valid & wr_ready.
// Signals: wr_valid (master->slave), wr_ready (slave->master),
//          addr_w [AW] and data_w [DW] (master->slave).
interface freq_gate_sequencer_if
  import freq_pkg::*;
#(
  parameter int DW = CNT_W_DEF,
  parameter int AW = ADDR_W
) ();

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] data_w;

  modport master (output wr_valid, output addr_w, output data_w, input  wr_ready);
  modport slave  (input  wr_valid, input  addr_w, input  data_w, output wr_ready);

endinterface

// File: rtl/freq_edge_sync.sv
// Brings the asynchronous waveform into clk and flags its rising edges.
// Latency: edge_pulse is high during the 3rd clk after the input rises.
// Backpressure: none; one pulse per synchronized rising edge.
// Ports: clk, reset_n (sync, active-low), din (async), edge_pulse (1-cycle).
module freq_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic edge_pulse
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign edge_pulse = sync_q2 & ~prev_q;

endmodule

// File: rtl/freq_gate_sequencer.sv
// Counts waveform rising edges over a fixed gate window and writes each count
// round-robin into the sample memory, then pulses the averager.
// Latency: result presented GATE_CYCLES clk after the gate opens; avg_start 1 clk after acceptance.
// Backpressure: WRITE holds the sample until wr_ready; edges in that wait are not counted.
// Ports: clk, reset_n (sync, active-low), waveform (async), run, wr (write channel
//        master), avg_start, filled, busy; ovf only when FREQ_OVF_SAT_EN is defined
//        (counter saturates instead of wrapping).
module freq_gate_sequencer
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  waveform,
  input  logic                  run,
  freq_gate_sequencer_if.master wr,
  output logic                  avg_start,
  output logic                  filled,
  output logic                  busy
`ifdef FREQ_OVF_SAT_EN
  ,
  output logic                  ovf
`endif
);

  localparam int               TMR_W    = $clog2(GATE_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       fill_cnt;
  logic             edge_pulse;
`ifdef FREQ_OVF_SAT_EN
  logic             sat_hit;
  logic             sat_nxt;
`endif

  freq_edge_sync u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (waveform),
    .edge_pulse (edge_pulse)
  );

  // Next count including this cycle's edge, so the last gate cycle is counted.
  always_comb begin
    cnt_nxt = cnt;
`ifdef FREQ_OVF_SAT_EN
    sat_nxt = sat_hit;
    if (edge_pulse) begin
      if (cnt == '1) sat_nxt = 1'b1;
      else           cnt_nxt = cnt + 1'b1;
    end
`else
    if (edge_pulse) cnt_nxt = cnt + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      cnt       <= '0;
      wr.addr_w <= '0;
      wr.data_w <= '0;
      fill_cnt  <= '0;
      avg_start <= 1'b0;
`ifdef FREQ_OVF_SAT_EN
      sat_hit   <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      avg_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state   <= ST_GATE;
            timer   <= TMR_LOAD;
            cnt     <= '0;
`ifdef FREQ_OVF_SAT_EN
            sat_hit <= 1'b0;
`endif
          end
        end
        ST_GATE: begin
          cnt   <= cnt_nxt;
          timer <= timer - 1'b1;
`ifdef FREQ_OVF_SAT_EN
          sat_hit <= sat_nxt;
`endif
          if (timer == '0) begin
            state     <= ST_WRITE;
            wr.data_w <= cnt_nxt;
          end
        end
        ST_WRITE: begin
          if (wr.wr_ready) begin
            wr.addr_w <= wr.addr_w + 1'b1;
            avg_start <= 1'b1;
            if (fill_cnt != 3'(DEPTH)) fill_cnt <= fill_cnt + 3'd1;
`ifdef FREQ_OVF_SAT_EN
            ovf <= sat_hit;
`endif
            // Back-to-back gates when still running; dead time is only the handshake.
            if (run) begin
              state   <= ST_GATE;
              timer   <= TMR_LOAD;
              cnt     <= '0;
`ifdef FREQ_OVF_SAT_EN
              sat_hit <= 1'b0;
`endif
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wr.wr_valid = (state == ST_WRITE);
  assign busy        = (state != ST_IDLE);
  assign filled      = (fill_cnt == 3'(DEPTH));

endmodule

// File: tb/tb_freq_gate_sequencer.sv
module tb_freq_gate_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  logic run, run2;
  logic wave_en, man_wave;
  logic wave2 = 1'b0;
  int   ph = 0;
  logic waveform;
  logic avg1, filled1, busy1;
  logic avg2, filled2, busy2;
`ifdef FREQ_OVF_SAT_EN
  logic ovf1, ovf2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_addr;
  logic [25:0] d_hold;
  logic [1:0]  a_hold;

  freq_gate_sequencer_if #(.DW(26), .AW(2)) w1 ();
  freq_gate_sequencer_if #(.DW(4),  .AW(2)) w2 ();

  freq_gate_sequencer #(.GATE_CYCLES(20), .CNT_W(26)) u_dut (
    .clk(clk), .reset_n(reset_n), .waveform(waveform), .run(run), .wr(w1),
    .avg_start(avg1), .filled(filled1), .busy(busy1)
`ifdef FREQ_OVF_SAT_EN
    , .ovf(ovf1)
`endif
  );

  freq_gate_sequencer #(.GATE_CYCLES(40), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .waveform(wave2), .run(run2), .wr(w2),
    .avg_start(avg2), .filled(filled2), .busy(busy2)
`ifdef FREQ_OVF_SAT_EN
    , .ovf(ovf2)
`endif
  );

  initial forever #5 clk = ~clk;

  // Period-4 waveform (2 high, 2 low) or manual level; period-2 waveform for the 4-bit DUT.
  always @(negedge clk) ph = ph + 1;
  always @(negedge clk) wave2 = ~wave2;
  assign waveform = wave_en ? ph[1] : man_wave;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_vld(input bit sel, input string tag);
    int n = 0;
    while (((sel ? w2.wr_valid : w1.wr_valid) !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; run = 1'b1; run2 = 1'b0;
    wave_en = 1'b1; man_wave = 1'b0;
    w1.wr_ready = 1'b1; w2.wr_ready = 1'b1;

    // 1. reset with run=1 and toggling waveform
    repeat (4) @(negedge clk);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_valid", 32'(w1.wr_valid), 0);
    chk("rst_avg", 32'(avg1), 0);
    chk("rst_addr", 32'(w1.addr_w), 0);
    chk("rst_filled", 32'(filled1), 0);
    chk("rst_busy4", 32'(busy2), 0);
`ifdef FREQ_OVF_SAT_EN
    chk("rst_ovf", 32'(ovf1), 0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_busy", 32'(busy1), 1);
    chk("rel_valid", 32'(w1.wr_valid), 0);

    // 2. continuous gates, wr_ready=1
    exp_addr = 0;
    for (int w = 0; w < 5; w++) begin
      wait_vld(1'b0, "t2");
      chk("t2_addr", 32'(w1.addr_w), 32'(exp_addr));
      if (w == 0) chk("t2_data_range", 32'(w1.data_w >= 4 && w1.data_w <= 6), 1);
      else        chk("t2_data", 32'(w1.data_w), 5);
      chk("t2_avg_idle", 32'(avg1), 0);
      @(negedge clk);
      chk("t2_avg_pulse", 32'(avg1), 1);
      chk("t2_filled", 32'(filled1), 32'(w >= 3));
      chk("t2_valid_drop", 32'(w1.wr_valid), 0);
      exp_addr = (exp_addr + 1) % 4;
      @(negedge clk);
      chk("t2_avg_single", 32'(avg1), 0);
    end

    // 3. wr_ready held low for 7 cycles
    w1.wr_ready = 1'b0;
    wait_vld(1'b0, "t3");
    a_hold = w1.addr_w;
    d_hold = w1.data_w;
    chk("t3_addr", 32'(a_hold), 32'(exp_addr));
    chk("t3_data", 32'(d_hold), 5);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t3_valid_hold", 32'(w1.wr_valid), 1);
      chk("t3_addr_hold", 32'(w1.addr_w), 32'(a_hold));
      chk("t3_data_hold", 32'(w1.data_w), 32'(d_hold));
      chk("t3_avg_wait", 32'(avg1), 0);
    end
    w1.wr_ready = 1'b1;
    @(negedge clk);
    chk("t3_avg_pulse", 32'(avg1), 1);
    chk("t3_valid_drop", 32'(w1.wr_valid), 0);
    exp_addr = (exp_addr + 1) % 4;
    @(negedge clk);
    chk("t3_avg_single", 32'(avg1), 0);

    // 4. run dropped mid-gate; the gate after the stall counts no dead-time edges
    repeat (5) @(negedge clk);
    run = 1'b0;
    wait_vld(1'b0, "t4");
    chk("t4_data", 32'(w1.data_w), 5);
    chk("t4_addr", 32'(w1.addr_w), 32'(exp_addr));
    @(negedge clk);
    chk("t4_avg", 32'(avg1), 1);
    chk("t4_idle", 32'(busy1), 0);
    exp_addr = (exp_addr + 1) % 4;
    repeat (10) @(negedge clk);
    chk("t4_stay_idle", 32'(busy1), 0);
    chk("t4_no_write", 32'(w1.wr_valid), 0);
    chk("t4_addr_kept", 32'(w1.addr_w), 32'(exp_addr));
    run = 1'b1;
    @(negedge clk);
    chk("t4_restart", 32'(busy1), 1);
    wait_vld(1'b0, "t4b");
    run = 1'b0;
    chk("t4b_addr", 32'(w1.addr_w), 32'(exp_addr));
    chk("t4b_data", 32'(w1.data_w), 5);
    @(negedge clk);
    chk("t4b_idle", 32'(busy1), 0);
    exp_addr = (exp_addr + 1) % 4;

    // 5. constant waveform; single edge on last gate cycle vs one cycle later
    wave_en = 1'b0; man_wave = 1'b0;
    repeat (6) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (17) @(negedge clk);
    man_wave = 1'b1;
    wait_vld(1'b0, "t5a");
    chk("t5_last_edge", 32'(w1.data_w), 1);
    chk("t5a_addr", 32'(w1.addr_w), 32'(exp_addr));
    @(negedge clk);
    chk("t5a_idle", 32'(busy1), 0);
    exp_addr = (exp_addr + 1) % 4;
    man_wave = 1'b0;
    repeat (6) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (18) @(negedge clk);
    man_wave = 1'b1;
    wait_vld(1'b0, "t5b");
    chk("t5_late_edge", 32'(w1.data_w), 0);
    @(negedge clk);
    exp_addr = (exp_addr + 1) % 4;
    man_wave = 1'b0;

    // 6. 4-bit counter, period-2 waveform, 40-cycle gate: 20 edges
    run2 = 1'b1;
    @(negedge clk);
    run2 = 1'b0;
    wait_vld(1'b1, "t6");
`ifdef FREQ_OVF_SAT_EN
    chk("t6_data_sat", 32'(w2.data_w), 15);
`else
    chk("t6_data_wrap", 32'(w2.data_w), 4);
`endif
    @(negedge clk);
    chk("t6_avg", 32'(avg2), 1);
`ifdef FREQ_OVF_SAT_EN
    chk("t6_ovf", 32'(ovf2), 1);
    chk("t6_ovf_main", 32'(ovf1), 0);
`endif

    // reset while a write is pending aborts it
    w1.wr_ready = 1'b0; wave_en = 1'b1; run = 1'b1;
    wait_vld(1'b0, "t7");
    reset_n = 1'b0;
    @(negedge clk);
    chk("t7_valid", 32'(w1.wr_valid), 0);
    chk("t7_busy", 32'(busy1), 0);
    chk("t7_addr", 32'(w1.addr_w), 0);
    chk("t7_filled", 32'(filled1), 0);
    chk("t7_avg", 32'(avg1), 0);
    run = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    chk("t7_idle", 32'(busy1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
